// File: rtl/piso_framer.sv
// Parallel-in, serial-out framer: start bit, WIDTH data bits, optional even parity, stop bit.
// Define PISO_PARITY_EN to add the PARITY state and even-parity bit after the data bits.
module piso_framer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             so,
    output logic             busy,
    output logic             frame_done
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             so_d;
    logic             accept;
    logic             out_bit;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign in_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept   = in_valid && in_ready;
    assign out_bit  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        so_d    = 1'b1;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                so_d    = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                so_d   = out_bit;
                sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                so_d    = parity_q;
                state_d = STOP;
            end
`endif
            STOP: begin
                // Accepting here chains the next frame with no idle gap.
                state_d = accept ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // accept only fires in IDLE/STOP, so this never collides with the DATA shift.
        if (accept) begin
            sreg_d = in_data;
            cnt_d  = CNT_LAST;
`ifdef PISO_PARITY_EN
            parity_d = ^in_data;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            so         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            so         <= so_d;
            busy       <= (state_q != IDLE);
            frame_done <= (state_q == STOP);
`ifdef PISO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_framer.sv
// Directed bench for piso_framer: MSB-first and LSB-first instances, WIDTH=8.
// Expected streams follow PISO_PARITY_EN when it is defined for the build.
module tb_piso_framer;

`ifdef PISO_PARITY_EN
    localparam int FL = 11;
    localparam logic [10:0] EXP_A5 = 11'b0_10100101_0_1;
    localparam logic [10:0] EXP_01 = 11'b0_10000000_1_1;
    localparam logic [10:0] EXP_FF = 11'b0_11111111_0_1;
    localparam logic [10:0] EXP_00 = 11'b0_00000000_0_1;
    localparam logic [10:0] EXP_07 = 11'b0_00000111_1_1;
`else
    localparam int FL = 10;
    localparam logic [10:0] EXP_A5 = 11'b0_10100101_1;
    localparam logic [10:0] EXP_01 = 11'b0_10000000_1;
    localparam logic [10:0] EXP_FF = 11'b0_11111111_1;
    localparam logic [10:0] EXP_00 = 11'b0_00000000_1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d_m, d_l;
    logic       v_m, v_l;
    logic       r_m, r_l, so_m, so_l, busy_m, busy_l, fd_m, fd_l;
    logic [3:0] ds;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    piso_framer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(d_m), .in_valid(v_m),
        .in_ready(r_m), .so(so_m), .busy(busy_m), .frame_done(fd_m)
    );

    piso_framer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(d_l), .in_valid(v_l),
        .in_ready(r_l), .so(so_l), .busy(busy_l), .frame_done(fd_l)
    );

    // Downstream 4-bit shift stage fed by the MSB-first instance.
    always @(posedge clk) ds <= {ds[2:0], so_m};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data,
                              input logic [10:0] exp, input string tag);
        if (sel) begin d_l = data; v_l = 1'b1; end
        else     begin d_m = data; v_m = 1'b1; end
        tick();
        check({tag, "_ready_after_accept"}, sel ? r_l : r_m, 1'b0);
        v_m = 1'b0;
        v_l = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            tick();
            check($sformatf("%s_so_%0d", tag, i), sel ? so_l : so_m, exp[FL-i]);
            check($sformatf("%s_busy_%0d", tag, i), sel ? busy_l : busy_m, 1'b1);
            check($sformatf("%s_done_%0d", tag, i), sel ? fd_l : fd_m, (i == FL));
        end
        tick();
        check({tag, "_idle_so"}, sel ? so_l : so_m, 1'b1);
        check({tag, "_idle_busy"}, sel ? busy_l : busy_m, 1'b0);
        check({tag, "_idle_ready"}, sel ? r_l : r_m, 1'b1);
    endtask

    initial begin
        logic [10:0] e1, e2;
        int pulses, first_fd, second_fd;

        // Reset held for 3 cycles with a valid word presented.
        rst_n = 1'b0;
        d_m = 8'h55; v_m = 1'b1;
        d_l = 8'h00; v_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_so", so_m, 1'b1);
            check("rst_busy", busy_m, 1'b0);
            check("rst_ready", r_m, 1'b1);
            check("rst_done", fd_m, 1'b0);
        end
        rst_n = 1'b1;
        v_m = 1'b0;
        tick();
        tick();
        check("post_rst_busy", busy_m, 1'b0);
        check("post_rst_so", so_m, 1'b1);

        // Single frames, MSB first then LSB first.
        send_frame(1'b0, 8'hA5, EXP_A5, "msb_a5");
        send_frame(1'b1, 8'h01, EXP_01, "lsb_01");

        // Back-to-back: valid held high, second word queued upstream.
        e1 = EXP_FF;
        e2 = EXP_00;
        pulses = 0; first_fd = 0; second_fd = 0;
        d_m = 8'hFF; v_m = 1'b1;
        tick();
        d_m = 8'h00;
        for (int i = 1; i <= 2*FL + 1; i++) begin
            tick();
            if (i <= FL)        check($sformatf("b2b_so_%0d", i), so_m, e1[FL-i]);
            else if (i <= 2*FL) check($sformatf("b2b_so_%0d", i), so_m, e2[2*FL-i]);
            else                check("b2b_so_idle", so_m, 1'b1);
            if (i == FL - 1) check("b2b_ready_in_stop", r_m, 1'b1);
            if (i == FL + 1) check("b2b_busy_gapfree", busy_m, 1'b1);
            if (fd_m) begin
                pulses++;
                if (pulses == 1) first_fd = i;
                else second_fd = i;
            end
            if (i == FL) v_m = 1'b0;
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_first_done", first_fd, FL);
        check("b2b_done_spacing", second_fd - first_fd, FL);

        // Reset during data bit 3 aborts the frame.
        d_m = 8'hA5; v_m = 1'b1;
        tick();
        v_m = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        check("abort_bit3", so_m, 1'b0);
        rst_n = 1'b0;
        tick();
        check("abort_so", so_m, 1'b1);
        check("abort_busy", busy_m, 1'b0);
        check("abort_done", fd_m, 1'b0);
        check("abort_ready", r_m, 1'b1);
        rst_n = 1'b1;
        tick();
        check("abort_stays_idle", busy_m, 1'b0);
        send_frame(1'b0, 8'hA5, EXP_A5, "after_abort");

`ifdef PISO_PARITY_EN
        // Parity frame, also observed through the downstream 4-bit stage.
        e1 = EXP_07;
        d_m = 8'h07; v_m = 1'b1;
        tick();
        v_m = 1'b0;
        for (int j = 1; j <= FL + 4; j++) begin
            tick();
            if (j <= FL) check($sformatf("par_so_%0d", j), so_m, e1[FL-j]);
            if (j == FL) check("par_stop_done", fd_m, 1'b1);
            if (j >= 5) check($sformatf("par_ds_%0d", j), ds[3], e1[FL-(j-4)]);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
